// File: rtl/tlk2711_pkg.sv
// Shared TLK2711 link definitions: control words, K-flag codes, word classes and
// the frame-state encoding used by both the receive framer and the transmitter.
package tlk2711_pkg;

  localparam logic [15:0] IDLE_WORD = 16'hBCC5;
  localparam logic [15:0] SOF_WORD  = 16'hFB00;
  localparam logic [15:0] EOF_WORD  = 16'hFD00;

  localparam logic [1:0] RK_DATA = 2'b00;
  localparam logic [1:0] RK_CTRL = 2'b10;
  localparam logic [1:0] RK_CERR = 2'b11;

  typedef enum logic [2:0] {
    WC_DATA, WC_IDLE, WC_SOF, WC_EOF, WC_CERR, WC_BADK
  } word_class_e;

  typedef enum logic [2:0] {
    FS_IDLE, FS_HDR, FS_PAYLOAD, FS_CSUM, FS_EOF
  } frame_state_e;

  typedef enum logic {
    SS_UNSYNC, SS_SYNC
  } sync_state_e;

  function automatic word_class_e classify(input logic [1:0] rk, input logic [15:0] rxd);
    word_class_e wc;
    case (rk)
      RK_DATA: wc = WC_DATA;
      RK_CERR: wc = WC_CERR;
      RK_CTRL: begin
        if (rxd == IDLE_WORD)     wc = WC_IDLE;
        else if (rxd == SOF_WORD) wc = WC_SOF;
        else if (rxd == EOF_WORD) wc = WC_EOF;
        else                      wc = WC_BADK;
      end
      default: wc = WC_BADK;
    endcase
    return wc;
  endfunction

endpackage

// File: rtl/tlk2711_rx_sync.sv
// Link synchroniser: acquires on a run of IDLE words, drops on a run of code errors.
module tlk2711_rx_sync
  import tlk2711_pkg::*;
#(
  parameter int SYNC_IDLES = 8,
  parameter int LOS_ERRS   = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  word_class_e wclass,
  output logic        sync
);

  // One run counter serves both states; it is cleared on every state change.
  localparam int RUN_MAX = (SYNC_IDLES > LOS_ERRS) ? SYNC_IDLES : LOS_ERRS;
  localparam int RW      = $clog2(RUN_MAX + 1);

  sync_state_e   state, state_n;
  logic [RW-1:0] run, run_n;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= SS_UNSYNC;
      run   <= '0;
    end else begin
      state <= state_n;
      run   <= run_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n = state;
    run_n   = '0;
    case (state)
      SS_UNSYNC: begin
        if (wclass == WC_IDLE) begin
          if (run == RW'(SYNC_IDLES - 1)) state_n = SS_SYNC;
          else                            run_n   = run + RW'(1);
        end
      end
      SS_SYNC: begin
        if (wclass == WC_CERR) begin
          if (run == RW'(LOS_ERRS - 1)) state_n = SS_UNSYNC;
          else                          run_n   = run + RW'(1);
        end
      end
      default: state_n = SS_UNSYNC;
    endcase
  end

  assign sync = (state == SS_SYNC);

endmodule

// File: rtl/tlk2711_rx_framer.sv
// TLK2711 receive framer: SOF / length / payload / checksum / EOF parsing with
// one-cycle payload delivery, frame status pulses and saturating statistics.
module tlk2711_rx_framer
  import tlk2711_pkg::*;
#(
  parameter int MAX_LEN    = 1024,
  parameter int SYNC_IDLES = 8,
  parameter int LOS_ERRS   = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [15:0] i_rxd,
  input  logic        i_rkmsb,
  input  logic        i_rklsb,
  input  logic        i_cnt_clr,
  output logic        o_sync,
  output logic [15:0] o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_frame_ok,
  output logic        o_frame_err,
  output logic [15:0] o_frame_cnt,
  output logic [15:0] o_err_cnt
);

  localparam logic [16:0] MAX_LEN_C = 17'(MAX_LEN);

  word_class_e  wclass;
  frame_state_e state, state_n;
  logic [15:0]  len, cnt, acc;
  logic         csum_bad;
  logic         len_ok, beat, beat_last, hdr_take, csum_take, ok_n, err_n;

  assign wclass = classify({i_rkmsb, i_rklsb}, i_rxd);
  assign len_ok = (i_rxd != 16'd0) && ({1'b0, i_rxd} <= MAX_LEN_C);

  tlk2711_rx_sync #(
    .SYNC_IDLES(SYNC_IDLES),
    .LOS_ERRS  (LOS_ERRS)
  ) u_sync (
    .clk   (clk),
    .arst_n(arst_n),
    .wclass(wclass),
    .sync  (o_sync)
  );

  always_comb begin
    state_n   = state;
    ok_n      = 1'b0;
    err_n     = 1'b0;
    beat      = 1'b0;
    beat_last = 1'b0;
    hdr_take  = 1'b0;
    csum_take = 1'b0;
    if (!o_sync) begin
      if (state != FS_IDLE) begin
        err_n   = 1'b1;
        state_n = FS_IDLE;
      end
    end else if (wclass == WC_SOF) begin
      // A new SOF always starts a frame; any frame in flight is reported as aborted.
      err_n   = (state != FS_IDLE);
      state_n = FS_HDR;
    end else begin
      unique case (state)
        FS_IDLE: state_n = FS_IDLE;
        FS_HDR: begin
          if (wclass == WC_DATA) begin
            hdr_take = 1'b1;
            if (len_ok) state_n = FS_PAYLOAD;
            else begin
              err_n   = 1'b1;
              state_n = FS_IDLE;
            end
          end else begin
            err_n   = 1'b1;
            state_n = FS_IDLE;
          end
        end
        FS_PAYLOAD: begin
          if (wclass == WC_DATA) begin
            beat      = 1'b1;
            beat_last = (cnt == len);
            if (beat_last) state_n = FS_CSUM;
          end else begin
            err_n   = 1'b1;
            state_n = FS_IDLE;
          end
        end
        FS_CSUM: begin
          if (wclass == WC_DATA) begin
            csum_take = 1'b1;
            state_n   = FS_EOF;
          end else begin
            err_n   = 1'b1;
            state_n = FS_IDLE;
          end
        end
        FS_EOF: begin
          state_n = FS_IDLE;
          if (wclass == WC_EOF) begin
            ok_n  = !csum_bad;
            err_n = csum_bad;
          end else begin
            err_n = 1'b1;
          end
        end
        default: state_n = FS_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= FS_IDLE;
      len         <= '0;
      cnt         <= '0;
      acc         <= '0;
      csum_bad    <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_last      <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      state       <= state_n;
      o_valid     <= beat;
      o_last      <= beat_last;
      o_frame_ok  <= ok_n;
      o_frame_err <= err_n;
      if (hdr_take) begin
        len <= i_rxd;
        acc <= '0;
        cnt <= 16'd1;
      end
      if (beat) begin
        o_data <= i_rxd;
        acc    <= acc + i_rxd;
        cnt    <= cnt + 16'd1;
      end
      if (csum_take) csum_bad <= (i_rxd != acc);
      // Clear has priority over a same-cycle increment.
      if (i_cnt_clr)                                 o_frame_cnt <= '0;
      else if (o_frame_ok && o_frame_cnt != 16'hFFFF) o_frame_cnt <= o_frame_cnt + 16'd1;
      if (i_cnt_clr)                                 o_err_cnt <= '0;
      else if (o_frame_err && o_err_cnt != 16'hFFFF)  o_err_cnt <= o_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tlk2711_rx_framer.sv
// Self-checking bench for tlk2711_rx_framer: frame table plus hand-written corner
// sequences, with a payload scoreboard checked by a negedge monitor.
module tb_tlk2711_rx_framer;
  import tlk2711_pkg::*;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [15:0] i_rxd = '0;
  logic        i_rkmsb = 1'b0, i_rklsb = 1'b0, i_cnt_clr = 1'b0;
  logic        o_sync, o_valid, o_last, o_frame_ok, o_frame_err;
  logic [15:0] o_data, o_frame_cnt, o_err_cnt;

  tlk2711_rx_framer #(.MAX_LEN(1024), .SYNC_IDLES(8), .LOS_ERRS(4)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .i_rxd      (i_rxd),
    .i_rkmsb    (i_rkmsb),
    .i_rklsb    (i_rklsb),
    .i_cnt_clr  (i_cnt_clr),
    .o_sync     (o_sync),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_last     (o_last),
    .o_frame_ok (o_frame_ok),
    .o_frame_err(o_frame_err),
    .o_frame_cnt(o_frame_cnt),
    .o_err_cnt  (o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic [31:0] cyc;
  } beat_t;

  typedef struct packed {
    logic [15:0]       len;
    logic [3:0][15:0]  w;
    logic [15:0]       csum;
    logic              exp_ok;
  } frame_t;

  int          checks = 0, errors = 0;
  int          cyc = 0, n_ok = 0, n_err = 0;
  int          exp_nok = 0, exp_nerr = 0;
  logic [15:0] exp_ok_cnt = '0, exp_err_cnt = '0;
  beat_t       sb[$];
  frame_t      tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    beat_t e;
    if (o_frame_ok) n_ok++;
    if (o_frame_err) n_err++;
    if (o_frame_ok && o_frame_err) check("ok_err_overlap", 32'(o_frame_ok & o_frame_err), 0);
    if (o_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 32'(o_valid), 0);
      end else begin
        e = sb.pop_front();
        check("beat_data", 32'(o_data), 32'(e.data));
        check("beat_last", 32'(o_last), 32'(e.last));
        check("beat_cycle", cyc, e.cyc);
      end
    end
  end

  function automatic frame_t mk(input logic [15:0] len, w0, w1, w2, w3, csum, input logic ok);
    frame_t f;
    f.len = len; f.w[0] = w0; f.w[1] = w1; f.w[2] = w2; f.w[3] = w3;
    f.csum = csum; f.exp_ok = ok;
    return f;
  endfunction

  task automatic send(input logic [1:0] rk, input logic [15:0] d);
    {i_rkmsb, i_rklsb} = rk;
    i_rxd = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [15:0] d);
    send(RK_DATA, d);
  endtask

  task automatic send_beat(input logic [15:0] d, input logic last);
    send(RK_DATA, d);
    sb.push_back('{data: d, last: last, cyc: cyc});
  endtask

  task automatic note_ok();
    exp_nok++;
    if (exp_ok_cnt != 16'hFFFF) exp_ok_cnt++;
  endtask

  task automatic note_err();
    exp_nerr++;
    if (exp_err_cnt != 16'hFFFF) exp_err_cnt++;
  endtask

  task automatic check_totals(input string tag);
    send(RK_CTRL, IDLE_WORD);
    send(RK_CTRL, IDLE_WORD);
    check({tag, "_ok_pulses"}, n_ok, exp_nok);
    check({tag, "_err_pulses"}, n_err, exp_nerr);
    check({tag, "_frame_cnt"}, 32'(o_frame_cnt), 32'(exp_ok_cnt));
    check({tag, "_err_cnt"}, 32'(o_err_cnt), 32'(exp_err_cnt));
  endtask

  task automatic run_frame(input frame_t f, input string tag);
    send(RK_CTRL, SOF_WORD);
    send_data(f.len);
    for (int i = 0; i < int'(f.len); i++) send_beat(f.w[i], i == int'(f.len) - 1);
    send_data(f.csum);
    send(RK_CTRL, EOF_WORD);
    check({tag, "_ok"}, 32'(o_frame_ok), 32'(f.exp_ok));
    check({tag, "_err"}, 32'(o_frame_err), 32'(!f.exp_ok));
    if (f.exp_ok) note_ok();
    else          note_err();
  endtask

  task automatic resync();
    for (int i = 0; i < 8; i++) send(RK_CTRL, IDLE_WORD);
  endtask

  initial begin
    logic [15:0] sum, d;

    tbl[0] = mk(16'd3, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 16'h0002, 1'b1);
    tbl[1] = mk(16'd3, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 16'h0003, 1'b0);
    tbl[2] = mk(16'd1, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b1);
    tbl[3] = mk(16'd4, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'hA000, 1'b1);
    tbl[4] = mk(16'd2, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFE, 1'b1);
    tbl[5] = mk(16'd4, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h0000, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_sync", 32'(o_sync), 0);
    check("rst_valid", 32'(o_valid), 0);
    check("rst_data", 32'(o_data), 0);
    check("rst_pulses", 32'({o_last, o_frame_ok, o_frame_err}), 0);
    check("rst_counters", {o_frame_cnt, o_err_cnt}, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Sync acquisition: a DATA word restarts the IDLE run
    for (int i = 0; i < 7; i++) send(RK_CTRL, IDLE_WORD);
    send_data(16'h1111);
    for (int i = 0; i < 7; i++) send(RK_CTRL, IDLE_WORD);
    check("sync_after_7", 32'(o_sync), 0);
    send(RK_CTRL, IDLE_WORD);
    check("sync_after_8", 32'(o_sync), 1);

    // Table-driven frames
    for (int i = 0; i < 6; i++) run_frame(tbl[i], $sformatf("tbl%0d", i));
    check_totals("table");

    // SOF inside a frame aborts it; the following frame completes
    send(RK_CTRL, SOF_WORD);
    send_data(16'd4);
    send_beat(16'h000A, 1'b0);
    send_beat(16'h000B, 1'b0);
    send(RK_CTRL, SOF_WORD);
    check("resof_err", 32'(o_frame_err), 1);
    note_err();
    send_data(16'd1);
    send_beat(16'h1234, 1'b1);
    send_data(16'h1234);
    send(RK_CTRL, EOF_WORD);
    check("resof_second_ok", 32'(o_frame_ok), 1);
    note_ok();
    check_totals("resof");

    // Length bounds: 0 and MAX_LEN+1 rejected, MAX_LEN accepted
    send(RK_CTRL, SOF_WORD);
    send_data(16'd0);
    check("len0_err", 32'(o_frame_err), 1);
    note_err();
    send(RK_CTRL, SOF_WORD);
    send_data(16'd1025);
    check("len1025_err", 32'(o_frame_err), 1);
    note_err();
    send(RK_CTRL, SOF_WORD);
    send_data(16'd1024);
    sum = '0;
    for (int k = 0; k < 1024; k++) begin
      d = 16'(k * 37 + 5);
      sum = sum + d;
      send_beat(d, k == 1023);
    end
    send_data(sum);
    send(RK_CTRL, EOF_WORD);
    check("len1024_ok", 32'(o_frame_ok), 1);
    note_ok();
    check_totals("lenbounds");

    // IDLE mid-payload aborts; a non-EOF after the checksum aborts
    send(RK_CTRL, SOF_WORD);
    send_data(16'd3);
    send_beat(16'h0055, 1'b0);
    send(RK_CTRL, IDLE_WORD);
    check("idle_abort_err", 32'(o_frame_err), 1);
    note_err();
    send(RK_CTRL, SOF_WORD);
    send_data(16'd1);
    send_beat(16'h0007, 1'b1);
    send_data(16'h0007);
    send_data(16'h0000);
    check("no_eof_err", 32'(o_frame_err), 1);
    note_err();
    check_totals("aborts");

    // Reset mid-frame discards the frame silently
    send(RK_CTRL, SOF_WORD);
    send_data(16'd2);
    send_beat(16'h0077, 1'b0);
    @(negedge clk);
    #2;
    arst_n = 1'b0;
    exp_ok_cnt  = '0;
    exp_err_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_err", 32'(o_frame_err), 0);
    check("midrst_sync", 32'(o_sync), 0);
    @(negedge clk);
    arst_n = 1'b1;
    resync();
    check_totals("midrst");

    // Clear wins over a simultaneous increment
    run_frame(tbl[0], "clr_frame");
    i_cnt_clr = 1'b1;
    send(RK_CTRL, IDLE_WORD);
    i_cnt_clr = 1'b0;
    exp_ok_cnt  = '0;
    exp_err_cnt = '0;
    check_totals("clr");

    // Saturate the error counter with back-to-back SOFs
    for (int i = 0; i < 65540; i++) begin
      send(RK_CTRL, SOF_WORD);
      if (i > 0) note_err();
    end
    check("sat_err_cnt", 32'(o_err_cnt), 32'hFFFF);

    // Code errors mid-payload: one abort, then loss of sync on the 4th
    send_data(16'd3);
    send_beat(16'h0101, 1'b0);
    send(RK_CERR, 16'h0000);
    check("cerr_abort_err", 32'(o_frame_err), 1);
    check("cerr_valid", 32'(o_valid), 0);
    note_err();
    send(RK_CERR, 16'h0000);
    send(RK_CERR, 16'h0000);
    check("cerr3_sync", 32'(o_sync), 1);
    send(RK_CERR, 16'h0000);
    check("cerr4_sync", 32'(o_sync), 0);
    check("cerr4_valid", 32'(o_valid), 0);
    check_totals("los");
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlk2711_rx_framer.md
TLK2711_RX_FRAMER -- requirements
Module: tlk2711_rx_framer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 1024, maximum payload words per frame.
REQ-002 SHALL have parameter SYNC_IDLES, default 8, consecutive IDLE words needed to acquire sync.
REQ-003 SHALL have parameter LOS_ERRS, default 4, consecutive code-error words that drop sync.
REQ-004 clk  input  1  receive clock, same domain as the TLK2711 rx_clk; single clock, no other clock.
REQ-005 arst_n  input  1  asynchronous active-low reset.
REQ-006 i_rxd  input  16  received word from TLK2711 RXD.
REQ-007 i_rkmsb  input  1  K flag, upper byte.
REQ-008 i_rklsb  input  1  K flag, lower byte.
REQ-009 i_cnt_clr  input  1  synchronous clear of statistics counters.
REQ-010 o_sync  output  1  link synchronised.
REQ-011 o_data  output  16  payload word.
REQ-012 o_valid  output  1  o_data valid; no backpressure.
REQ-013 o_last  output  1  last payload word of frame, qualified by o_valid.
REQ-014 o_frame_ok  output  1  one-cycle pulse: frame ended with good checksum and EOF.
REQ-015 o_frame_err  output  1  one-cycle pulse: frame aborted, bad length, bad checksum or missing EOF.
REQ-016 o_frame_cnt  output  16  good-frame count, saturating.
REQ-017 o_err_cnt  output  16  frame-error count, saturating.

Function
REQ-018 Word classes (rk = {i_rkmsb,i_rklsb}): IDLE = rk 10, rxd 16'hBCC5; SOF = rk 10, rxd 16'hFB00; EOF = rk 10, rxd 16'hFD00; CODE_ERR = rk 11; DATA = rk 00; any other K word = BAD_K.
REQ-019 Sync FSM: UNSYNC -> SYNC after SYNC_IDLES consecutive IDLE words; any non-IDLE resets the run count; o_sync = 1 in SYNC.
REQ-020 In SYNC, LOS_ERRS consecutive CODE_ERR words -> UNSYNC; any non-CODE_ERR word clears the error run count.
REQ-021 Frame FSM states: IDLE, HDR, PAYLOAD, CSUM, EOF; advances only while o_sync = 1.
REQ-022 IDLE: SOF -> HDR; all other words ignored.
REQ-023 HDR: DATA word = payload length L; 1 <= L <= MAX_LEN -> PAYLOAD; L = 0 or L > MAX_LEN -> o_frame_err, -> IDLE.
REQ-024 PAYLOAD: each DATA word output on o_data/o_valid exactly 1 cycle after it is sampled; o_last on word L; after word L -> CSUM.
REQ-025 Checksum = 16-bit sum, modulo 2^16, of the L payload words; accumulator cleared in HDR.
REQ-026 CSUM: DATA word equal to checksum -> EOF; mismatch -> flag pending error, -> EOF.
REQ-027 EOF: EOF word -> o_frame_ok (or o_frame_err if mismatch pending) 1 cycle later; any other word -> o_frame_err, -> IDLE.
REQ-028 SOF received in HDR/PAYLOAD/CSUM/EOF: o_frame_err pulse for the old frame, -> HDR for the new frame; o_last not asserted for the aborted frame.
REQ-029 Any IDLE, EOF, BAD_K or CODE_ERR in HDR/PAYLOAD/CSUM: o_frame_err, -> IDLE.
REQ-030 Loss of sync mid-frame: o_frame_err, frame FSM -> IDLE, o_valid = 0 from the next cycle.
REQ-031 o_frame_ok and o_frame_err are never asserted in the same cycle.
REQ-032 Counters increment on o_frame_ok / o_frame_err, hold at 16'hFFFF; i_cnt_clr wins over a simultaneous increment.

Reset
REQ-033 On arst_n low, all outputs = 0, sync FSM = UNSYNC, frame FSM = IDLE, run counts, accumulator and length counter = 0.
REQ-034 Reset mid-frame SHALL discard the frame without an o_frame_err pulse.

Structure
REQ-035 Package tlk2711_pkg holds the IDLE/SOF/EOF word and K-flag constants and the frame-state enumeration; tlk2711 TX uses the same package.
REQ-036 Sync FSM with its run counters is sub-module tlk2711_rx_sync; all framing logic stays in the top.

Verification
REQ-037 Reset, 7 IDLEs then 1 DATA then 8 IDLEs -> o_sync rises only after the 8th IDLE of the second run.
REQ-038 Synced, SOF, L=3, words 0x0001/0x0002/0xFFFF, csum 0x0002, EOF -> 3 o_valid beats, o_last on 0xFFFF, o_frame_ok pulse, o_frame_cnt = 1.
REQ-039 Same frame with csum 0x0003 -> 3 beats delivered, o_frame_err pulse, o_err_cnt = 1, o_frame_cnt unchanged.
REQ-040 SOF, L=4, 2 words, SOF, L=1, word 0x1234, csum 0x1234, EOF -> o_frame_err for the first frame, no o_last on it, o_frame_ok for the second.
REQ-041 HDR L=0 and HDR L=1025 -> o_frame_err each, no o_valid.
REQ-042 Mid-payload, 4 CODE_ERR words -> o_sync = 0, o_frame_err once, o_valid = 0; o_err_cnt preset to 0xFFFF stays 0xFFFF.
